// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiply datapath: mantissa and
// exponent widths, the mantissa-multiplier FSM state, and the aligned
// result record handed to the rounding stage.
package fp_mul_pkg;

  localparam int MANT_W = 24;
  localparam int EXP_W  = 10;
  localparam int PROD_W = 2 * MANT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [MANT_W-1:0]       mant;
    logic                    g;
    logic                    r;
    logic                    s;
    logic signed [EXP_W-1:0] exp;
    logic                    sign;
    logic                    zero;
  } result_t;

endpackage

// File: rtl/fp_mant_mult_seq_if.sv
// Operand/result handshake bundle for the iterative mantissa multiplier.
// master drives operands and accepts results; slave is the multiplier.
interface fp_mant_mult_seq_if #(
  parameter int MANT_W = fp_mul_pkg::MANT_W,
  parameter int EXP_W  = fp_mul_pkg::EXP_W
);
  import fp_mul_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic [MANT_W-1:0]       norm_a_mant;
  logic [MANT_W-1:0]       norm_b_mant;
  logic signed [EXP_W-1:0] exp_sum;
  logic                    sign_in;

  logic                    out_valid;
  logic                    out_ready;
  logic [MANT_W-1:0]       prod_mant;
  logic                    guard_bit;
  logic                    round_bit;
  logic                    sticky_bit;
  logic signed [EXP_W-1:0] exp_out;
  logic                    sign_out;
  logic                    prod_zero;

  modport master (
    output in_valid, norm_a_mant, norm_b_mant, exp_sum, sign_in, out_ready,
    input  in_ready, out_valid, prod_mant, guard_bit, round_bit, sticky_bit,
           exp_out, sign_out, prod_zero
  );

  modport slave (
    input  in_valid, norm_a_mant, norm_b_mant, exp_sum, sign_in, out_ready,
    output in_ready, out_valid, prod_mant, guard_bit, round_bit, sticky_bit,
           exp_out, sign_out, prod_zero
  );

endinterface

// File: rtl/fp_prod_align.sv
// Combinational alignment of a full double-width mantissa product into the
// MANT_W result mantissa plus guard/round/sticky, with the exponent bumped
// when the product carried into the top bit. Denormal products are not
// normalized further here.
module fp_prod_align #(
  parameter int MANT_W = fp_mul_pkg::MANT_W,
  parameter int EXP_W  = fp_mul_pkg::EXP_W
) (
  input  logic [2*MANT_W-1:0]     p,
  input  logic signed [EXP_W-1:0] exp_sum,
  output logic [MANT_W-1:0]       prod_mant,
  output logic                    guard_bit,
  output logic                    round_bit,
  output logic                    sticky_bit,
  output logic signed [EXP_W-1:0] exp_out,
  output logic                    prod_zero
);
  import fp_mul_pkg::*;

  logic carry;

  assign carry = p[2*MANT_W-1];

  // Select the mantissa window and rounding bits by product carry.
  always_comb begin
    prod_mant  = p[2*MANT_W-2 -: MANT_W];
    guard_bit  = p[MANT_W-2];
    round_bit  = p[MANT_W-3];
    sticky_bit = |p[MANT_W-4:0];
    exp_out    = exp_sum;
    if (carry) begin
      prod_mant  = p[2*MANT_W-1 -: MANT_W];
      guard_bit  = p[MANT_W-1];
      round_bit  = p[MANT_W-2];
      sticky_bit = |p[MANT_W-3:0];
      // Exponent wraps in EXP_W; range handling belongs to the rounder.
      exp_out    = exp_sum + EXP_W'(1);
    end
    prod_zero = (p == '0);
  end

endmodule

// File: rtl/fp_mant_mult_seq.sv
// Iterative shift-add mantissa multiplier: one partial product per clock,
// MANT_W iterations, then the product is aligned and held until the
// downstream stage accepts it.
// Optional macro FP_MANT_MULT_EARLY_TERM_EN: finish as soon as the remaining
// multiplier bits are all zero instead of always running MANT_W iterations.
module fp_mant_mult_seq #(
  parameter int MANT_W = fp_mul_pkg::MANT_W,
  parameter int EXP_W  = fp_mul_pkg::EXP_W
) (
  input  logic               clk,
  input  logic               rst,
  fp_mant_mult_seq_if.slave  bus
);
  import fp_mul_pkg::*;

  localparam int PW    = 2 * MANT_W;
  localparam int CNT_W = $clog2(MANT_W + 1);

  state_t                  state;
  logic [PW-1:0]           mcand;
  logic [MANT_W-1:0]       mlt;
  logic [PW-1:0]           acc;
  logic [CNT_W-1:0]        cnt;
  logic signed [EXP_W-1:0] exp_q;
  logic                    sign_q;

  logic                    out_valid_q;
  logic [MANT_W-1:0]       prod_mant_q;
  logic                    guard_q;
  logic                    round_q;
  logic                    sticky_q;
  logic signed [EXP_W-1:0] exp_out_q;
  logic                    sign_out_q;
  logic                    zero_q;

  logic [PW-1:0]           acc_next;
  logic                    finish;

  logic [MANT_W-1:0]       al_mant;
  logic                    al_g;
  logic                    al_r;
  logic                    al_s;
  logic signed [EXP_W-1:0] al_exp;
  logic                    al_zero;

  // Accumulate this iteration's partial product; decide whether it is the last.
  always_comb begin
    acc_next = acc + (mlt[0] ? mcand : '0);
    finish   = (cnt == CNT_W'(MANT_W - 1));
`ifdef FP_MANT_MULT_EARLY_TERM_EN
    // With no multiplier bits left the accumulator already holds the product
    // (acc_next equals acc because nothing is added).
    finish   = finish || (mlt == '0);
`endif
  end

  fp_prod_align #(
    .MANT_W (MANT_W),
    .EXP_W  (EXP_W)
  ) u_align (
    .p          (acc_next),
    .exp_sum    (exp_q),
    .prod_mant  (al_mant),
    .guard_bit  (al_g),
    .round_bit  (al_r),
    .sticky_bit (al_s),
    .exp_out    (al_exp),
    .prod_zero  (al_zero)
  );

  // Control FSM with the shift-add datapath and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mcand       <= '0;
      mlt         <= '0;
      acc         <= '0;
      cnt         <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      prod_mant_q <= '0;
      guard_q     <= 1'b0;
      round_q     <= 1'b0;
      sticky_q    <= 1'b0;
      exp_out_q   <= '0;
      sign_out_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {{MANT_W{1'b0}}, bus.norm_a_mant};
            mlt    <= bus.norm_b_mant;
            exp_q  <= bus.exp_sum;
            sign_q <= bus.sign_in;
            acc    <= '0;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc   <= acc_next;
          mcand <= {mcand[PW-2:0], 1'b0};
          mlt   <= {1'b0, mlt[MANT_W-1:1]};
          cnt   <= cnt + CNT_W'(1);
          if (finish) begin
            prod_mant_q <= al_mant;
            guard_q     <= al_g;
            round_q     <= al_r;
            sticky_q    <= al_s;
            exp_out_q   <= al_exp;
            sign_out_q  <= sign_q;
            zero_q      <= al_zero;
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = out_valid_q;
  assign bus.prod_mant  = prod_mant_q;
  assign bus.guard_bit  = guard_q;
  assign bus.round_bit  = round_q;
  assign bus.sticky_bit = sticky_q;
  assign bus.exp_out    = exp_out_q;
  assign bus.sign_out   = sign_out_q;
  assign bus.prod_zero  = zero_q;

endmodule
